// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns rising edges on trig into pulses HOLD cycles high, at least GAP cycles apart.
// Events that arrive mid-pulse are counted and replayed in order; drops on a full queue set a sticky flag.
module pulse_stretcher #(
  parameter int HOLD   = 10000,
  parameter int GAP    = 10000,
  parameter int PEND_W = 4,
  parameter int CW     = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CW-1:0]     HOLD_END = CW'(HOLD - 1);
  localparam logic [CW-1:0]     GAP_END  = CW'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              out_q, out_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              trig_q;
  logic              ev, want, start;

  // Queue update: a starting pulse eats the fresh event if there is one, else a queued one.
  function automatic logic [PEND_W-1:0] pend_update(input logic [PEND_W-1:0] p,
                                                    input logic ev_i, input logic start_i);
    logic [PEND_W-1:0] r;
    r = p;
    if (start_i && !ev_i)               r = p - PEND_W'(1);
    else if (!start_i && ev_i && p != PEND_MAX) r = p + PEND_W'(1);
    return r;
  endfunction

  function automatic logic dropped(input logic [PEND_W-1:0] p, input logic ev_i,
                                   input logic start_i);
    return ev_i && !start_i && (p == PEND_MAX);
  endfunction

  assign ev   = trig & ~trig_q;
  assign want = ev | (pend_q != '0);

  always_ff @(posedge clk) begin
    trig_q <= trig;
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      out_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (want) begin
          state_d = HIGH;
          count_d = '0;
          start   = 1'b1;
        end
      end
      HIGH: begin
        if (count_q == HOLD_END) begin
          state_d = LOW;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      LOW: begin
        if (count_q == GAP_END) begin
          count_d = '0;
          if (want) begin
            state_d = HIGH;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Set beats clear when a drop coincides with clr_ovf.
  always_comb begin
    out_d  = (state_d == HIGH);
    pend_d = pend_update(pend_q, ev, start);
    ovf_d  = dropped(pend_q, ev, start) | (ovf_q & ~clr_ovf);
    busy   = (state_q != IDLE);
  end

  assign out      = out_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: timeline model (pulse start times + event count) checked every cycle,
// plus directed patterns with hand-derived expectations.
module tb_pulse_stretcher;
  localparam int HOLD = 4, GAP = 3, PEND_W = 2, CW = 4;
  localparam int QMAX = (1 << PEND_W) - 1;

  logic clk = 1'b0, reset = 1'b1, trig = 1'b0, clr_ovf = 1'b0;
  logic out, busy, overflow;
  logic [PEND_W-1:0] pending;

  int checks = 0, errors = 0;

  pulse_stretcher #(.HOLD(HOLD), .GAP(GAP), .PEND_W(PEND_W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .trig(trig), .clr_ovf(clr_ovf),
    .out(out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: a pulse started at edge s is high after edges s..s+HOLD-1 and busy through s+HOLD+GAP-1;
  // the next pulse may start at any edge >= s+HOLD+GAP.
  initial begin
    int n, last, q, ovf;
    logic pt, r, t, c, ev, set;
    n = 0; last = -1000; q = 0; ovf = 0; pt = 1'b0;
    forever begin
      @(posedge clk);
      r = reset; t = trig; c = clr_ovf;
      n++;
      if (r) begin
        last = -1000; q = 0; ovf = 0;
      end else begin
        ev  = t && !pt;
        set = 1'b0;
        if (n >= last + HOLD + GAP && (ev || q > 0)) begin
          last = n;
          if (!ev) q--;
        end else if (ev) begin
          if (q == QMAX) set = 1'b1;
          else q++;
        end
        if (set) ovf = 1;
        else if (c) ovf = 0;
      end
      pt = t;
      #1;
      chk("out", int'(out), int'(n - last < HOLD));
      chk("busy", int'(busy), int'(n - last < HOLD + GAP));
      chk("pending", int'(pending), q);
      chk("overflow", int'(overflow), ovf);
    end
  end

  logic a_out[64], a_busy[64], a_ovf[64];
  int   a_pend[64];

  task automatic run(input logic [63:0] tp, input logic [63:0] cp, input logic [63:0] rp,
                     input int len);
    for (int i = 0; i < len; i++) begin
      trig = tp[i]; clr_ovf = cp[i]; reset = rp[i];
      @(posedge clk); #2;
      a_out[i] = out; a_busy[i] = busy; a_ovf[i] = overflow; a_pend[i] = int'(pending);
    end
    trig = 1'b0; clr_ovf = 1'b0; reset = 1'b0;
  endtask

  function automatic int sum_out(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(a_out[i]);
    return s;
  endfunction

  function automatic int rises(input int len);
    int s = 0;
    for (int i = 1; i < len; i++) if (a_out[i] && !a_out[i-1]) s++;
    return s + int'(a_out[0]);
  endfunction

  function automatic int max_pend(input int len);
    int m = 0;
    for (int i = 0; i < len; i++) if (a_pend[i] > m) m = a_pend[i];
    return m;
  endfunction

  initial begin
    // Reset state
    run(64'h0, 64'h0, 64'h3, 4);
    chk("rst_out", int'(a_out[1]), 0);
    chk("rst_busy", int'(a_busy[1]), 0);
    chk("rst_pend", a_pend[1], 0);
    chk("rst_ovf", int'(a_ovf[1]), 0);

    // Single event
    run(64'h1, 64'h0, 64'h0, 10);
    chk("t1_out0", int'(a_out[0]), 1);
    chk("t1_out3", int'(a_out[3]), 1);
    chk("t1_out4", int'(a_out[4]), 0);
    chk("t1_busy6", int'(a_busy[6]), 1);
    chk("t1_busy7", int'(a_busy[7]), 0);

    // Level-held trig
    run(64'h0, 64'h0, 64'h3, 3);
    run(64'h3FFF_FFFF, 64'h0, 64'h0, 40);
    chk("t2_highs", sum_out(0, 39), 4);
    chk("t2_pulses", rises(40), 1);
    chk("t2_pend", max_pend(40), 0);

    // Queue replay
    run(64'h0, 64'h0, 64'h3, 3);
    run(64'h55, 64'h0, 64'h0, 40);
    chk("t3_pend6", a_pend[6], 3);
    chk("t3_gap_lo", int'(a_out[6]), 0);
    chk("t3_gap_hi", int'(a_out[7]), 1);
    chk("t3_highs", sum_out(0, 39), 16);
    chk("t3_pulses", rises(40), 4);
    chk("t3_busy28", int'(a_busy[28]), 0);
    chk("t3_drain", a_pend[39], 0);

    // Overflow, set-wins, then clear
    run(64'h0, 64'h0, 64'h3, 3);
    run(64'h1555, 64'h3000, 64'h0, 20);
    chk("t4_pend8", a_pend[8], 3);
    chk("t4_ovf9", int'(a_ovf[9]), 0);
    chk("t4_ovf10", int'(a_ovf[10]), 1);
    chk("t4_pend10", a_pend[10], 3);
    chk("t4_ovf12", int'(a_ovf[12]), 1);
    chk("t4_ovf13", int'(a_ovf[13]), 0);
    chk("t4_pend14", a_pend[14], 2);

    // Reset mid-pulse with trig held through release
    run(64'h0, 64'h0, 64'h3, 3);
    run(64'h1FF_FF55, 64'h0, 64'h300, 30);
    chk("t5_out7", int'(a_out[7]), 1);
    chk("t5_pend7", a_pend[7], 2);
    chk("t5_out8", int'(a_out[8]), 0);
    chk("t5_pend8", a_pend[8], 0);
    chk("t5_busy8", int'(a_busy[8]), 0);
    chk("t5_quiet", sum_out(8, 29), 0);

    // Event on the last low cycle
    run(64'h0, 64'h0, 64'h3, 3);
    run(64'h81, 64'h0, 64'h0, 14);
    chk("t6_out3", int'(a_out[3]), 1);
    chk("t6_low", sum_out(4, 6), 0);
    chk("t6_out7", int'(a_out[7]), 1);
    chk("t6_busy6", int'(a_busy[6]), 1);
    chk("t6_busy7", int'(a_busy[7]), 1);
    chk("t6_pend", max_pend(14), 0);

    run(64'h0, 64'h0, 64'h0, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
